// File: rtl/sprite_sched_pkg.sv
// Shared types for the sprite attribute fetch scheduler: FSM state encoding
// and the byte offsets of the per-sprite attribute fields.
package sprite_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CPU_ACC  = 3'd1,
        S_CPU_RESP = 3'd2,
        S_FETCH_Y  = 3'd3,
        S_FETCH_X  = 3'd4,
        S_EMIT     = 3'd5
    } state_e;

    localparam logic ATTR_Y_OFS = 1'b0;
    localparam logic ATTR_X_OFS = 1'b1;

endpackage

// File: rtl/sprite_fetch_scheduler.sv
// Per-scanline sprite attribute walker that time-shares the single-port
// attribute RAM with CPU register accesses between scans.
module sprite_fetch_scheduler
    import sprite_sched_pkg::*;
#(
    parameter int NUM_SPRITES = 4,
    parameter int SPR_H       = 16,
    parameter int IDX_W       = $clog2(NUM_SPRITES),
    parameter int ADDR_W      = IDX_W + 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      line_start,
    input  logic [7:0]                next_y,
    input  logic                      cpu_req,
    input  logic                      cpu_we,
    input  logic [ADDR_W-1:0]         cpu_addr,
    input  logic [7:0]                cpu_wdata,
    output logic                      cpu_ack,
    output logic [7:0]                cpu_rdata,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic                      mem_we,
    output logic [7:0]                mem_wdata,
    input  logic [7:0]                mem_rdata,
    output logic                      ld_valid,
    output logic [IDX_W-1:0]          ld_idx,
    output logic [$clog2(SPR_H)-1:0]  ld_row,
    output logic [7:0]                ld_x,
    output logic                      ld_hit,
    output logic                      done,
    output logic                      overrun
);

    localparam int ROW_W = $clog2(SPR_H);

    state_e             r_state, w_state_next;
    logic [IDX_W-1:0]   r_idx;
    logic [7:0]         r_ny;
    logic [7:0]         r_y;
    logic               r_pending;
    logic               r_overrun;
    logic               r_we;
    logic [7:0]         r_rdata;
    logic               r_ld_valid;
    logic [IDX_W-1:0]   r_ld_idx;
    logic [ROW_W-1:0]   r_ld_row;
    logic [7:0]         r_ld_x;
    logic               r_ld_hit;
    logic               r_done;

    logic               w_scan_start;
    logic               w_last;
    logic               w_in_cpu;
    logic               w_in_scan;
    logic [7:0]         w_diff;

    assign w_scan_start = (r_state == S_IDLE) && (line_start || r_pending);
    assign w_last       = (r_idx == IDX_W'(NUM_SPRITES - 1));
    assign w_in_cpu     = (r_state == S_CPU_ACC) || (r_state == S_CPU_RESP);
    assign w_in_scan    = (r_state == S_FETCH_Y) || (r_state == S_FETCH_X) || (r_state == S_EMIT);
    // Modulo-256 subtraction makes sprites straddling line 255/0 wrap naturally.
    assign w_diff       = r_ny - r_y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (line_start || r_pending) w_state_next = S_FETCH_Y;
                else if (cpu_req)            w_state_next = S_CPU_ACC;
            end
            S_CPU_ACC:  w_state_next = S_CPU_RESP;
            S_CPU_RESP: w_state_next = S_IDLE;
            S_FETCH_Y:  w_state_next = S_FETCH_X;
            S_FETCH_X:  w_state_next = S_EMIT;
            S_EMIT:     w_state_next = w_last ? S_IDLE : S_FETCH_Y;
            default:    w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = 8'h00;
        cpu_ack   = 1'b0;
        cpu_rdata = r_rdata;
        case (r_state)
            S_CPU_ACC: begin
                mem_addr  = cpu_addr;
                mem_we    = cpu_we;
                mem_wdata = cpu_wdata;
            end
            S_CPU_RESP: begin
                cpu_ack = 1'b1;
                if (!r_we) cpu_rdata = mem_rdata;
            end
            S_FETCH_Y: mem_addr = {r_idx, ATTR_Y_OFS};
            S_FETCH_X: mem_addr = {r_idx, ATTR_X_OFS};
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx      <= '0;
            r_ny       <= 8'h00;
            r_y        <= 8'h00;
            r_pending  <= 1'b0;
            r_overrun  <= 1'b0;
            r_we       <= 1'b0;
            r_rdata    <= 8'h00;
            r_ld_valid <= 1'b0;
            r_ld_idx   <= '0;
            r_ld_row   <= '0;
            r_ld_x     <= 8'h00;
            r_ld_hit   <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_ld_valid <= 1'b0;
            r_done     <= 1'b0;
            if (w_scan_start) begin
                r_idx     <= '0;
                r_ny      <= next_y;
                r_pending <= 1'b0;
            end else if (line_start && w_in_cpu) begin
                r_pending <= 1'b1;
            end
            if (line_start && w_in_scan) r_overrun <= 1'b1;
            if (r_state == S_CPU_ACC) r_we <= cpu_we;
            if (r_state == S_CPU_RESP && !r_we) r_rdata <= mem_rdata;
            if (r_state == S_FETCH_X) r_y <= mem_rdata;
            if (r_state == S_EMIT) begin
                r_ld_valid <= 1'b1;
                r_ld_idx   <= r_idx;
                r_ld_x     <= mem_rdata;
                r_ld_row   <= w_diff[ROW_W-1:0];
                r_ld_hit   <= (w_diff[7:ROW_W] == '0);
                r_done     <= w_last;
                if (!w_last) r_idx <= r_idx + 1'b1;
            end
        end
    end

    assign ld_valid = r_ld_valid;
    assign ld_idx   = r_ld_idx;
    assign ld_row   = r_ld_row;
    assign ld_x     = r_ld_x;
    assign ld_hit   = r_ld_hit;
    assign done     = r_done;
    assign overrun  = r_overrun;

endmodule

// File: tb/tb_sprite_fetch_scheduler.sv
// Directed bench for sprite_fetch_scheduler with a synchronous-read RAM model
// and hand-computed descriptor tables.
module tb_sprite_fetch_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       line_start = 1'b0;
    logic [7:0] next_y = 8'h00;
    logic       cpu_req = 1'b0;
    logic       cpu_we = 1'b0;
    logic [2:0] cpu_addr = 3'd0;
    logic [7:0] cpu_wdata = 8'h00;
    logic       cpu_ack;
    logic [7:0] cpu_rdata;
    logic [2:0] mem_addr;
    logic       mem_we;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata = 8'h00;
    logic       ld_valid;
    logic [1:0] ld_idx;
    logic [3:0] ld_row;
    logic [7:0] ld_x;
    logic       ld_hit;
    logic       done;
    logic       overrun;

    sprite_fetch_scheduler #(.NUM_SPRITES(4), .SPR_H(16)) dut (
        .clk(clk), .rst_n(rst_n), .line_start(line_start), .next_y(next_y),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .ld_valid(ld_valid), .ld_idx(ld_idx), .ld_row(ld_row), .ld_x(ld_x), .ld_hit(ld_hit),
        .done(done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] ram [0:7];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    int ld_cnt = 0;
    int done_cnt = 0;
    int ld_cyc [64];
    int ld_idx_a [64];
    int ld_row_a [64];
    int ld_x_a [64];
    int ld_hit_a [64];
    int done_cyc [64];

    always @(negedge clk) begin
        if (ld_valid && ld_cnt < 64) begin
            ld_cyc[ld_cnt]   <= cyc;
            ld_idx_a[ld_cnt] <= int'(ld_idx);
            ld_row_a[ld_cnt] <= int'(ld_row);
            ld_x_a[ld_cnt]   <= int'(ld_x);
            ld_hit_a[ld_cnt] <= int'(ld_hit);
            ld_cnt <= ld_cnt + 1;
        end
        if (done && done_cnt < 64) begin
            done_cyc[done_cnt] <= cyc;
            done_cnt <= done_cnt + 1;
        end
    end

    int total = 0;
    int bad = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // ls_mode: 0 = no line_start, 1 = line_start together with cpu_req,
    // 2 = line_start during the ack (CPU_RESP) cycle.
    task automatic cpu_xfer(input logic we, input logic [2:0] addr, input logic [7:0] wd,
                            input int ls_mode, input logic [7:0] ny,
                            output logic [7:0] rd, output int lat, output int t_ls);
        int c0;
        c0 = cyc;
        t_ls = -1;
        rd = 8'h00;
        lat = -1;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        if (ls_mode == 1) begin
            next_y = ny; line_start = 1'b1; t_ls = cyc;
        end
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ls_mode == 1) line_start = 1'b0;
            if (cpu_ack) begin
                lat = cyc - c0;
                rd = cpu_rdata;
                break;
            end
        end
        cpu_req = 1'b0; cpu_we = 1'b0;
        if (ls_mode == 2) begin
            next_y = ny; line_start = 1'b1; t_ls = cyc;
            @(negedge clk);
            line_start = 1'b0;
        end
        $display("cpu %s addr=%0d wdata=%02h rdata=%02h lat=%0d", we ? "wr" : "rd", addr, wd, rd, lat);
        @(negedge clk);
    endtask

    task automatic pulse_ls(input logic [7:0] ny, output int t0);
        next_y = ny;
        line_start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        line_start = 1'b0;
    endtask

    task automatic check_scan(input string tag, input int base, input int dbase, input int t0,
                              input int eh [4], input int er [4], input int ex [4]);
        check_val({tag, " ld count"}, ld_cnt - base, 4);
        check_val({tag, " done count"}, done_cnt - dbase, 1);
        if (done_cnt > dbase) check_val({tag, " done cycle"}, done_cyc[dbase] - t0, 13);
        for (int i = 0; i < 4; i++) begin
            if (base + i < ld_cnt) begin
                check_val($sformatf("%s ld%0d cycle", tag, i), ld_cyc[base+i] - t0, 4 + 3*i);
                check_val($sformatf("%s ld%0d idx", tag, i), ld_idx_a[base+i], i);
                check_val($sformatf("%s ld%0d x", tag, i), ld_x_a[base+i], ex[i]);
                check_val($sformatf("%s ld%0d hit", tag, i), ld_hit_a[base+i], eh[i]);
                check_val($sformatf("%s ld%0d row", tag, i), ld_row_a[base+i], er[i]);
            end
        end
        $display("scan %s: t0=%0d lds=%0d dones=%0d", tag, t0, ld_cnt - base, done_cnt - dbase);
    endtask

    initial begin
        int t0, lat, tl, base, dbase;
        logic [7:0] rd;
        int ys [4] = '{10, 20, 250, 100};
        int h25 [4] = '{1, 1, 0, 0};
        int r25 [4] = '{15, 5, 15, 5};
        int h2 [4]  = '{0, 0, 1, 0};
        int r2 [4]  = '{8, 14, 8, 14};
        int xs [4]  = '{1, 2, 3, 4};

        repeat (2) @(negedge clk);
        check_val("reset outs", int'({ld_valid, done, cpu_ack, mem_we, overrun, ld_hit}), 0);
        check_val("reset mem_addr", int'(mem_addr), 0);
        check_val("reset ld_x/row", int'({ld_x, ld_row, ld_idx}), 0);
        check_val("reset cpu_rdata", int'(cpu_rdata), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            cpu_xfer(1'b1, 3'(2*i), 8'(ys[i]), 0, 8'h00, rd, lat, tl);
            check_val($sformatf("wr y%0d lat", i), lat, 2);
            cpu_xfer(1'b1, 3'(2*i+1), 8'(xs[i]), 0, 8'h00, rd, lat, tl);
            check_val($sformatf("wr x%0d lat", i), lat, 2);
        end
        cpu_xfer(1'b0, 3'd4, 8'h00, 0, 8'h00, rd, lat, tl);
        check_val("rd y2", int'(rd), 250);

        // Basic scan, next_y=25
        base = ld_cnt; dbase = done_cnt;
        pulse_ls(8'd25, t0);
        repeat (16) @(negedge clk);
        check_scan("ny25", base, dbase, t0, h25, r25, xs);

        // Vertical wrap, next_y=2
        base = ld_cnt; dbase = done_cnt;
        pulse_ls(8'd2, t0);
        repeat (16) @(negedge clk);
        check_scan("ny2", base, dbase, t0, h2, r2, xs);

        // Scan start beats cpu_req in the same IDLE cycle
        base = ld_cnt; dbase = done_cnt;
        cpu_xfer(1'b1, 3'd5, 8'h77, 1, 8'd25, rd, lat, tl);
        check_val("collide ack lat", lat, 15);
        check_scan("collide", base, dbase, tl, h25, r25, xs);
        cpu_xfer(1'b0, 3'd5, 8'h00, 0, 8'h00, rd, lat, tl);
        check_val("readback", int'(rd), 8'h77);
        check_val("readback lat", lat, 2);
        cpu_xfer(1'b1, 3'd5, 8'd3, 0, 8'h00, rd, lat, tl);

        // line_start in CPU_RESP is deferred via pending
        base = ld_cnt; dbase = done_cnt;
        cpu_xfer(1'b0, 3'd2, 8'h00, 2, 8'd25, rd, lat, tl);
        check_val("pend rd data", int'(rd), 20);
        check_val("pend rd lat", lat, 2);
        repeat (14) @(negedge clk);
        check_scan("pending", base, dbase, tl + 1, h25, r25, xs);
        check_val("pending no overrun", int'(overrun), 0);

        // Second line_start mid-scan
        base = ld_cnt; dbase = done_cnt;
        pulse_ls(8'd25, t0);
        repeat (3) @(negedge clk);
        line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
        check_val("overrun set", int'(overrun), 1);
        repeat (16) @(negedge clk);
        check_val("overrun sticky", int'(overrun), 1);
        check_scan("overrun", base, dbase, t0, h25, r25, xs);

        // Reset mid-scan
        base = ld_cnt; dbase = done_cnt;
        pulse_ls(8'd25, t0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("midrst outs", int'({ld_valid, done, cpu_ack, mem_we, overrun, ld_hit}), 0);
        check_val("midrst mem_addr", int'(mem_addr), 0);
        check_val("midrst ld_x/row", int'({ld_x, ld_row, ld_idx}), 0);
        check_val("midrst lds before", ld_cnt - base, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        base = ld_cnt;
        repeat (20) @(negedge clk);
        check_val("post rst no ld", ld_cnt - base, 0);
        check_val("post rst no done", done_cnt - dbase, 0);
        check_val("post rst overrun", int'(overrun), 0);
        $display("reset mid-scan at t0+6 done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
